// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: opcodes,
// format codes, skid-buffer state encoding and the stored entry metadata.
package imm_gen_pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int unsigned FMT_W = 3;

    localparam logic [FMT_W-1:0] FMT_R = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic             illegal;
    } dec_meta_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Purely combinational RV32I/RV64I immediate decoder, sign-extended to XLEN.
module imm_decode_comb
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]      instr,
    output logic [XLEN-1:0]  imm,
    output logic [FMT_W-1:0] fmt,
    output logic             illegal
);

    logic [6:0]  opcode;
    logic [31:0] imm32;
    logic        sgn;

    assign opcode = instr[6:0];
    assign sgn    = instr[31];

    // Every format fits in 32 bits; widening to XLEN is a plain sign extension.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
                fmt   = FMT_I;
                imm32 = {{20{sgn}}, instr[31:20]};
            end
            OP_IMM32: begin
                if (XLEN == 32'd64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{sgn}}, instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{sgn}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_REG, OP_SYSTEM: begin
                fmt = FMT_R;
            end
            OP_REG32: begin
                illegal = (XLEN != 32'd64);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a valid/ready interface with a 2-entry skid
// buffer and a saturating count of accepted illegal instructions.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [FMT_W-1:0]  out_fmt,
    output logic              out_illegal,
    input  logic              clear_count,
    output logic [CNT_W-1:0]  illegal_count
);

    logic [XLEN-1:0]  dec_imm;
    logic [FMT_W-1:0] dec_fmt;
    logic             dec_illegal;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    skid_state_e      state_q, state_d;
    logic [XLEN-1:0]  head_imm_q, head_imm_d;
    logic [XLEN-1:0]  tail_imm_q, tail_imm_d;
    dec_meta_t        head_meta_q, head_meta_d;
    dec_meta_t        tail_meta_q, tail_meta_d;
    dec_meta_t        dec_meta;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    assign dec_meta = '{fmt: dec_fmt, illegal: dec_illegal};

    // Ready depends only on registered state (and is held low during reset).
    assign in_ready  = rst_n & (state_q != SKID_TWO);
    assign out_valid = (state_q != SKID_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_imm_d  = head_imm_q;
        head_meta_d = head_meta_q;
        tail_imm_d  = tail_imm_q;
        tail_meta_d = tail_meta_q;
        case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    head_imm_d  = dec_imm;
                    head_meta_d = dec_meta;
                    state_d     = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    head_imm_d  = dec_imm;
                    head_meta_d = dec_meta;
                end else if (push) begin
                    tail_imm_d  = dec_imm;
                    tail_meta_d = dec_meta;
                    state_d     = SKID_TWO;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (pop) begin
                    head_imm_d  = tail_imm_q;
                    head_meta_d = tail_meta_q;
                    state_d     = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    // Clear wins over a coincident illegal accept; count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (push && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            head_imm_q  <= '0;
            head_meta_q <= '0;
            tail_imm_q  <= '0;
            tail_meta_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_imm_q  <= head_imm_d;
            head_meta_q <= head_meta_d;
            tail_imm_q  <= tail_imm_d;
            tail_meta_q <= tail_meta_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_imm       = head_imm_q;
    assign out_fmt       = head_meta_q.fmt;
    assign out_illegal   = head_meta_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=64/CNT_W=16 and XLEN=32/CNT_W=2 instances share
// stimulus; a queue-based reference model plus fixed vectors check both.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        clear_count;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [15:0] cnt64;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [1:0]  cnt32;

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
        .clear_count(clear_count), .illegal_count(cnt64)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32),
        .clear_count(clear_count), .illegal_count(cnt32)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
    } ent_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t mq[$];
    int   mc64 = 0;
    int   mc32 = 0;
    logic [6:0] ops[15];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint x, input int n);
        longint half;
        half = longint'(1) <<< (n - 1);
        return (x >= half) ? x - 2 * half : x;
    endfunction

    // Reference decode from the format rules using plain arithmetic.
    function automatic ent_t ref_dec(input logic [31:0] i);
        ent_t   e;
        longint v;
        logic   legal64, legal32;
        e = '0;
        e.instr = i;
        v = 0;
        legal64 = 1'b1;
        legal32 = 1'b1;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: begin
                e.fmt = 3'd1; v = sx(longint'(i[31:20]), 12);
            end
            7'h1B: begin
                e.fmt = 3'd1; v = sx(longint'(i[31:20]), 12); legal32 = 1'b0;
            end
            7'h23: begin
                e.fmt = 3'd2; v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                       longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4; v = sx(longint'(i[31:12]) * 4096, 32);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = sx(longint'(i[31]) * (longint'(1) <<< 20) + longint'(i[19:12]) * 4096 +
                       longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            end
            7'h33, 7'h73: e.fmt = 3'd0;
            7'h3B: legal32 = 1'b0;
            default: begin
                legal64 = 1'b0; legal32 = 1'b0;
            end
        endcase
        if (!legal64) begin
            e.fmt = 3'd0; v = 0;
        end
        e.imm   = v;
        e.ill   = !legal64;
        e.fmt32 = legal32 ? e.fmt : 3'd0;
        e.imm32 = legal32 ? e.imm[31:0] : 32'd0;
        e.ill32 = !legal32;
        return e;
    endfunction

    task automatic check_outputs();
        cmp("in_ready64", 64'(in_ready64), 64'(mq.size() < 2));
        cmp("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
        cmp("out_valid64", 64'(out_valid64), 64'(mq.size() > 0));
        cmp("out_valid32", 64'(out_valid32), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            cmp("imm64", out_imm64, mq[0].imm);
            cmp("fmt64", 64'(out_fmt64), 64'(mq[0].fmt));
            cmp("ill64", 64'(out_illegal64), 64'(mq[0].ill));
            cmp("imm32", 64'(out_imm32), 64'(mq[0].imm32));
            cmp("fmt32", 64'(out_fmt32), 64'(mq[0].fmt32));
            cmp("ill32", 64'(out_illegal32), 64'(mq[0].ill32));
        end
        cmp("count64", 64'(cnt64), 64'(mc64));
        cmp("count32", 64'(cnt32), 64'(mc32));
    endtask

    // One clock of stimulus; model advances with the handshakes it predicts.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                        input logic clr, output logic pushed);
        logic popped;
        ent_t e;
        check_outputs();
        in_valid    = v;
        in_instr    = ins;
        out_ready   = ordy;
        clear_count = clr;
        pushed = v && (mq.size() < 2);
        popped = ordy && (mq.size() > 0);
        e = ref_dec(ins);
        @(posedge clk);
        #1;
        if (popped) void'(mq.pop_front());
        if (pushed) mq.push_back(e);
        if (clr) begin
            mc64 = 0;
            mc32 = 0;
        end else if (pushed) begin
            if (e.ill && mc64 < 65535) mc64++;
            if (e.ill32 && mc32 < 3) mc32++;
        end
    endtask

    ent_t        vec[12];
    logic        p;
    logic [31:0] bp_instr[3];
    int          idx;
    logic [31:0] r;

    initial begin
        vec[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0};
        vec[1]  = '{32'hFE512C23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 32'hFFFFFFF8, 3'd2, 1'b0};
        vec[2]  = '{32'h00000863, 64'h0000000000000010, 3'd3, 1'b0, 32'h00000010, 3'd3, 1'b0};
        vec[3]  = '{32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0, 32'h12345000, 3'd4, 1'b0};
        vec[4]  = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, 32'hFFFFFFFC, 3'd5, 1'b0};
        vec[5]  = '{32'h0000007F, 64'h0000000000000000, 3'd0, 1'b1, 32'h00000000, 3'd0, 1'b1};
        vec[6]  = '{32'h00000033, 64'h0000000000000000, 3'd0, 1'b0, 32'h00000000, 3'd0, 1'b0};
        vec[7]  = '{32'h0010009B, 64'h0000000000000001, 3'd1, 1'b0, 32'h00000000, 3'd0, 1'b1};
        vec[8]  = '{32'h0000003B, 64'h0000000000000000, 3'd0, 1'b0, 32'h00000000, 3'd0, 1'b1};
        vec[9]  = '{32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0};
        vec[10] = '{32'h7FF00013, 64'h00000000000007FF, 3'd1, 1'b0, 32'h000007FF, 3'd1, 1'b0};
        vec[11] = '{32'h00100073, 64'h0000000000000000, 3'd0, 1'b0, 32'h00000000, 3'd0, 1'b0};

        ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h73, 7'h3B, 7'h7F, 7'h00};
        bp_instr = '{32'hFFF00093, 32'h123450B7, 32'hFFDFF06F};

        rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; clear_count = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        cmp("rst_out_valid", 64'(out_valid64), 64'd0);
        cmp("rst_in_ready", 64'(in_ready64), 64'd0);
        cmp("rst_imm", out_imm64, 64'd0);
        cmp("rst_fmt", 64'(out_fmt64), 64'd0);
        cmp("rst_illegal", 64'(out_illegal64), 64'd0);
        cmp("rst_count", 64'(cnt64), 64'd0);
        #8 rst_n = 1'b1;
        #1 cmp("post_rst_in_ready", 64'(in_ready64), 64'd1);

        // Fixed vectors, back-to-back with out_ready held high.
        foreach (vec[k]) begin
            step(1'b1, vec[k].instr, 1'b1, 1'b0, p);
            cmp("vec_valid", 64'(out_valid64), 64'd1);
            cmp("vec_imm64", out_imm64, vec[k].imm);
            cmp("vec_fmt64", 64'(out_fmt64), 64'(vec[k].fmt));
            cmp("vec_ill64", 64'(out_illegal64), 64'(vec[k].ill));
            cmp("vec_imm32", 64'(out_imm32), 64'(vec[k].imm32));
            cmp("vec_fmt32", 64'(out_fmt32), 64'(vec[k].fmt32));
            cmp("vec_ill32", 64'(out_illegal32), 64'(vec[k].ill32));
        end
        step(1'b0, '0, 1'b1, 1'b1, p);

        // Back-pressure: three offered, only two accepted while stalled.
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(idx < 3, bp_instr[idx % 3], 1'b0, 1'b0, p);
            if (p) idx++;
        end
        cmp("bp_accepted", 64'(idx), 64'd2);
        for (int c = 0; c < 5; c++) begin
            step(idx < 3, bp_instr[idx % 3], 1'b1, 1'b0, p);
            if (p) idx++;
        end
        cmp("bp_all_accepted", 64'(idx), 64'd3);

        // Illegal counting, clear priority, and saturation of the 2-bit counter.
        for (int c = 0; c < 3; c++) step(1'b1, 32'h0000007F, 1'b1, 1'b0, p);
        cmp("ill_cnt3_64", 64'(cnt64), 64'd3);
        cmp("ill_cnt3_32", 64'(cnt32), 64'd3);
        step(1'b1, 32'h0000007F, 1'b1, 1'b1, p);
        cmp("ill_clear64", 64'(cnt64), 64'd0);
        cmp("ill_clear32", 64'(cnt32), 64'd0);
        for (int c = 0; c < 5; c++) step(1'b1, 32'h0000007F, 1'b1, 1'b0, p);
        cmp("ill_cnt5_64", 64'(cnt64), 64'd5);
        cmp("ill_sat32", 64'(cnt32), 64'd3);
        step(1'b0, '0, 1'b1, 1'b0, p);

        // Asynchronous reset with two entries buffered.
        step(1'b1, 32'h0000007F, 1'b0, 1'b0, p);
        step(1'b1, 32'hFE512C23, 1'b0, 1'b0, p);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        cmp("amid_out_valid", 64'(out_valid64), 64'd0);
        cmp("amid_out_valid32", 64'(out_valid32), 64'd0);
        cmp("amid_in_ready", 64'(in_ready64), 64'd0);
        cmp("amid_count", 64'(cnt64), 64'd0);
        cmp("amid_imm", out_imm64, 64'd0);
        mq.delete();
        mc64 = 0;
        mc32 = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        cmp("arel_in_ready", 64'(in_ready64), 64'd1);
        cmp("arel_out_valid", 64'(out_valid64), 64'd0);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b0, p);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            r = $urandom();
            ops[14] = r[6:0];
            step($urandom_range(0, 3) != 0,
                 {r[31:7], ops[$urandom_range(0, 14)]},
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0, p);
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
